// File: rtl/chk_pkg.sv
// ============================================================================
//  Package     : chk_pkg
//  Description : Shared types and constants for the out_vec_checker response
//                checker (FSM state encoding, MISR polynomial and seed).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chk_pkg;

    // Checker FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_EXP = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_COMPARE  = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    // Galois MISR feedback taps: x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] MISR_POLY = 32'h0040_0007;
    localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/out_vec_checker_misr32.sv
// ============================================================================
//  Module      : misr32
//  Description : 32-bit Galois MISR. The data word is zero-extended to a
//                multiple of 32 bits and XOR-folded to 32 bits before being
//                compacted into the signature.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module misr32
    import chk_pkg::*;
#(
    parameter int OUT_WIDTH = 123
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [OUT_WIDTH-1:0] data,
    output logic [31:0]          sig
);

    localparam int NCHUNK = (OUT_WIDTH + 31) / 32;

    logic [NCHUNK*32-1:0] pad_w;
    logic [31:0]          fold_w;
    logic [31:0]          sig_q;
    logic [31:0]          sig_d;

    assign pad_w = (NCHUNK*32)'(data);

    // Fold all 32-bit chunks together and advance the Galois register
    always_comb begin
        fold_w = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            fold_w = fold_w ^ pad_w[c*32 +: 32];
        end
        sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold_w;
    end

    // Signature register: seeded on reset or clear, updated when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= MISR_SEED;
        end else if (clr) begin
            sig_q <= MISR_SEED;
        end else if (en) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/out_vec_checker.sv
// ============================================================================
//  Module      : out_vec_checker
//  Description : Response checker for vector-apply runs. Accepts one expected
//                word per applied vector, waits a settle time, samples the
//                DUT outputs, counts mismatches and compacts the responses
//                into a 32-bit MISR signature.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_vec_checker
    import chk_pkg::*;
#(
    parameter int OUT_WIDTH  = 123,
    parameter int VEC_LENGTH = 31,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 exp_valid,
    input  logic [OUT_WIDTH-1:0] exp_data,
    output logic                 exp_ready,
    input  logic [OUT_WIDTH-1:0] dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 err_flag,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     first_err_idx,
    output logic [CNT_W-1:0]     vec_idx,
    output logic [31:0]          signature
);

    // Run length counter is sized from VEC_LENGTH so a narrow CNT_W cannot
    // cut a run short; the index outputs are views of it.
    localparam int VW = $clog2(VEC_LENGTH + 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [3:0]             cnt_q;
    logic [OUT_WIDTH-1:0]   exp_q;
    logic [OUT_WIDTH-1:0]   samp_q;
    logic [VW-1:0]          vcnt_q;
    logic [CNT_W-1:0]       err_cnt_q;
    logic [CNT_W-1:0]       first_q;
    logic                   have_err_q;
    logic                   pass_q;
    logic                   err_flag_q;

    logic                   mismatch_w;
    logic [VW-1:0]          vnext_w;
    logic                   last_w;

    assign mismatch_w = (samp_q != exp_q);
    assign vnext_w    = vcnt_q + 1'b1;
    assign last_w     = (vnext_w == VW'(VEC_LENGTH));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start)      state_d = ST_WAIT_EXP;
            ST_WAIT_EXP: if (exp_valid)  state_d = ST_SETTLE;
            ST_SETTLE:   if (cnt_q == 4'd0) state_d = ST_COMPARE;
            ST_COMPARE:  state_d = last_w ? ST_FINISH : ST_WAIT_EXP;
            ST_FINISH:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        exp_ready = (state_q == ST_WAIT_EXP);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FINISH);
    end

    // Datapath: expected latch, settle timing, sampling, error bookkeeping.
    // The settle counter runs SETTLE_CYC down to 0, so dut_out is captured on
    // the edge SETTLE_CYC+1 cycles after the handshake and compared in COMPARE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 4'd0;
            exp_q      <= '0;
            samp_q     <= '0;
            vcnt_q     <= '0;
            err_cnt_q  <= '0;
            first_q    <= '1;
            have_err_q <= 1'b0;
            pass_q     <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            err_flag_q <= (state_q == ST_COMPARE) && mismatch_w;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        vcnt_q     <= '0;
                        err_cnt_q  <= '0;
                        first_q    <= '1;
                        have_err_q <= 1'b0;
                        pass_q     <= 1'b0;
                    end
                end
                ST_WAIT_EXP: begin
                    if (exp_valid) begin
                        exp_q <= exp_data;
                        cnt_q <= 4'(SETTLE_CYC);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == 4'd0) begin
                        samp_q <= dut_out;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_COMPARE: begin
                    if (mismatch_w) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                        if (!have_err_q) begin
                            first_q    <= CNT_W'(vcnt_q);
                            have_err_q <= 1'b1;
                        end
                    end
                    vcnt_q <= vnext_w;
                    if (last_w) begin
                        pass_q <= (err_cnt_q == '0) && !mismatch_w;
                    end
                end
                default: ;
            endcase
        end
    end

    misr32 #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state_q == ST_IDLE) && start),
        .en   (state_q == ST_COMPARE),
        .data (samp_q),
        .sig  (signature)
    );

    assign pass          = pass_q;
    assign err_flag      = err_flag_q;
    assign err_count     = err_cnt_q;
    assign first_err_idx = first_q;
    assign vec_idx       = CNT_W'(vcnt_q);

endmodule

`default_nettype wire

// File: tb/tb_out_vec_checker.sv
// ============================================================================
//  Module      : tb_out_vec_checker
//  Description : Self-checking bench for out_vec_checker. Three instances
//                (default sizing, single-vector signature, 2-bit counters)
//                share one driver selected by sel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_vec_checker;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         valid = 1'b0;
    logic [122:0] exp_data = '0;
    logic [122:0] dut_out = '0;
    int           sel = 0;

    int n_chk  = 0;
    int n_pass = 0;

    logic [122:0] vexp [32];
    logic [122:0] vres [32];

    always #5 clk = ~clk;

    // per-instance handshake inputs
    logic st0, st1, st2, v0, v1, v2;
    assign st0 = start && (sel == 0);
    assign st1 = start && (sel == 1);
    assign st2 = start && (sel == 2);
    assign v0  = valid && (sel == 0);
    assign v1  = valid && (sel == 1);
    assign v2  = valid && (sel == 2);

    logic        rdy0, busy0, done0, pass0, ef0;
    logic [15:0] ec0, fe0, vi0;
    logic [31:0] sg0;
    logic        rdy1, busy1, done1, pass1, ef1;
    logic [15:0] ec1, fe1, vi1;
    logic [31:0] sg1;
    logic        rdy2, busy2, done2, pass2, ef2;
    logic [1:0]  ec2, fe2, vi2;
    logic [31:0] sg2;

    out_vec_checker u_dut0 (
        .clk(clk), .rst(rst), .start(st0), .exp_valid(v0), .exp_data(exp_data),
        .exp_ready(rdy0), .dut_out(dut_out), .busy(busy0), .done(done0),
        .pass(pass0), .err_flag(ef0), .err_count(ec0), .first_err_idx(fe0),
        .vec_idx(vi0), .signature(sg0)
    );

    out_vec_checker #(.OUT_WIDTH(123), .VEC_LENGTH(1), .SETTLE_CYC(3), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .exp_valid(v1), .exp_data(exp_data),
        .exp_ready(rdy1), .dut_out(dut_out), .busy(busy1), .done(done1),
        .pass(pass1), .err_flag(ef1), .err_count(ec1), .first_err_idx(fe1),
        .vec_idx(vi1), .signature(sg1)
    );

    out_vec_checker #(.OUT_WIDTH(8), .VEC_LENGTH(5), .SETTLE_CYC(2), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(st2), .exp_valid(v2), .exp_data(exp_data[7:0]),
        .exp_ready(rdy2), .dut_out(dut_out[7:0]), .busy(busy2), .done(done2),
        .pass(pass2), .err_flag(ef2), .err_count(ec2), .first_err_idx(fe2),
        .vec_idx(vi2), .signature(sg2)
    );

    logic        o_rdy, o_busy, o_done, o_pass, o_ef;
    logic [15:0] o_ec, o_fe, o_vi;
    logic [31:0] o_sg;

    always_comb begin
        o_rdy = rdy0; o_busy = busy0; o_done = done0; o_pass = pass0; o_ef = ef0;
        o_ec = ec0; o_fe = fe0; o_vi = vi0; o_sg = sg0;
        if (sel == 1) begin
            o_rdy = rdy1; o_busy = busy1; o_done = done1; o_pass = pass1; o_ef = ef1;
            o_ec = ec1; o_fe = fe1; o_vi = vi1; o_sg = sg1;
        end else if (sel == 2) begin
            o_rdy = rdy2; o_busy = busy2; o_done = done2; o_pass = pass2; o_ef = ef2;
            o_ec = {14'd0, ec2}; o_fe = {14'd0, fe2}; o_vi = {14'd0, vi2}; o_sg = sg2;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [122:0] rnd123();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[122:0];
    endfunction

    // Reference MISR: bit-by-bit application of the tap rules
    function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [122:0] d, input int w);
        logic [31:0] f;
        logic [31:0] nx;
        f = '0;
        for (int b = 0; b < w; b++) f[b % 32] = f[b % 32] ^ d[b];
        for (int i = 0; i < 32; i++) begin
            nx[i] = ((i == 0) ? 1'b0 : s[i-1]) ^ f[i];
            if (i == 0 || i == 1 || i == 2 || i == 22) nx[i] = nx[i] ^ s[31];
        end
        return nx;
    endfunction

    // One complete run on instance inst, checked against the reference model
    task automatic run(input string nm, input int inst, input int n, input int s,
                       input int w, input int cw, input bit bp, input bit spam);
        logic [122:0] mask;
        logic [31:0]  msig;
        longint       cmask;
        int           nerr, first, k, cyc, flags;
        bit           got;
        mask  = '0;
        for (int b = 0; b < w; b++) mask[b] = 1'b1;
        cmask = (longint'(1) << cw) - 1;
        msig  = 32'hFFFF_FFFF;
        nerr  = 0;
        first = -1;
        for (int j = 0; j < n; j++) begin
            if (((vres[j] ^ vexp[j]) & mask) != '0) begin
                nerr++;
                if (first < 0) first = j;
            end
            msig = misr_ref(msig, vres[j] & mask, w);
        end
        sel = inst;
        k = 0; cyc = 0; flags = 0; got = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (cyc < 4000) begin
            if (o_ef) flags++;
            if (o_done) begin
                got = 1'b1;
                break;
            end
            valid    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            exp_data = vexp[(k < n) ? k : 0] & mask;
            if (valid && o_rdy && k < n) begin
                dut_out = vres[k] & mask;
                k++;
            end
            start = (spam && o_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        valid = 1'b0;
        chk({nm, "_done_seen"}, 64'(got), 64'd1);
        if (!bp) chk({nm, "_latency"}, 64'(cyc), 64'(1 + n * (s + 3)));
        chk({nm, "_handshakes"}, 64'(k), 64'(n));
        chk({nm, "_err_flags"}, 64'(flags), 64'(nerr));
        chk({nm, "_err_count"}, 64'(o_ec), (64'(nerr) > cmask) ? cmask : 64'(nerr));
        chk({nm, "_first_err"}, 64'(o_fe), (first < 0) ? cmask : (64'(first) & cmask));
        chk({nm, "_vec_idx"}, 64'(o_vi), 64'(n) & cmask);
        chk({nm, "_pass"}, 64'(o_pass), 64'(nerr == 0));
        chk({nm, "_signature"}, 64'(o_sg), 64'(msig));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 64'(o_done), 64'd0);
        chk({nm, "_idle"}, {62'd0, o_busy, o_rdy}, 64'd0);
        chk({nm, "_pass_held"}, 64'(o_pass), 64'(nerr == 0));
    endtask

    initial begin
        // ---------------- reset, then reset mid-run ----------------
        repeat (3) @(negedge clk);
        chk("rst_sig", 64'(o_sg), 64'hFFFF_FFFF);
        chk("rst_first", 64'(o_fe), 64'hFFFF);
        rst = 1'b0;
        sel = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; valid = 1'b1;
        exp_data = rnd123(); dut_out = ~exp_data;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rdy",   64'(o_rdy),  64'd0);
        chk("midrst_busy",  64'(o_busy), 64'd0);
        chk("midrst_done",  64'(o_done), 64'd0);
        chk("midrst_pass",  64'(o_pass), 64'd0);
        chk("midrst_eflag", 64'(o_ef),   64'd0);
        chk("midrst_ecnt",  64'(o_ec),   64'd0);
        chk("midrst_first", 64'(o_fe),   64'hFFFF);
        chk("midrst_vidx",  64'(o_vi),   64'd0);
        chk("midrst_sig",   64'(o_sg),   64'hFFFF_FFFF);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_after_rst", {61'd0, o_done, o_busy, o_rdy}, 64'd0);
        end
        valid = 1'b0;

        // ---------------- clean run ----------------
        for (int j = 0; j < 32; j++) begin
            vexp[j] = rnd123();
            vres[j] = vexp[j];
        end
        run("clean", 0, 31, 1, 123, 16, 1'b0, 1'b0);

        // ---------------- backpressure + start spam, same data ----------------
        run("bp", 0, 31, 1, 123, 16, 1'b1, 1'b1);

        // ---------------- injected errors on vectors 5 and 20 ----------------
        for (int j = 0; j < 32; j++) begin
            vexp[j] = rnd123();
            vres[j] = vexp[j];
        end
        vres[5][122]  = ~vres[5][122];
        vres[20][122] = ~vres[20][122];
        run("inj", 0, 31, 1, 123, 16, 1'b0, 1'b0);

        // ---------------- single-vector signature, run twice ----------------
        vexp[0] = 123'd1;
        vres[0] = 123'd1;
        run("sig1", 1, 1, 3, 123, 16, 1'b0, 1'b0);
        run("sig2", 1, 1, 3, 123, 16, 1'b0, 1'b0);

        // ---------------- 2-bit error counter saturation ----------------
        for (int j = 0; j < 5; j++) begin
            vexp[j] = rnd123();
            vres[j] = vexp[j];
            vres[j][0] = ~vres[j][0];
        end
        run("sat", 2, 5, 2, 8, 2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
